// File: rtl/sigma_pkg.sv
// Shared definitions for the Sigma memory-port block mover: bus widths,
// mover state encoding and the address wrap mask.
package sigma_pkg;

  localparam int unsigned SIGMA_ADDR_W = 17;
  localparam int unsigned SIGMA_DATA_W = 32;

  // Word pointers wrap modulo 2^17
  localparam logic [16:0] SIGMA_ADDR_MASK = 17'h1FFFF;

  typedef enum logic [1:0] {
    StIdle,
    StRead,
    StWrite,
    StDone
  } mover_state_e;

endpackage

// File: rtl/sigma_block_mover.sv
// Block fill / block copy initiator on the Sigma word-addressed memory port.
// Address bits are numbered [15:31], data bits [0:31] (big-endian numbering).
// Optional feature: define MOVER_CHECKSUM_EN to add the `checksum` output, a
// wrapping 32-bit sum of every word written by the current command.
module sigma_block_mover
  import sigma_pkg::*;
#(
  parameter int unsigned ADDR_W = SIGMA_ADDR_W,
  parameter int unsigned DATA_W = SIGMA_DATA_W
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_copy,
  input  logic [32-ADDR_W:31]   cmd_src,
  input  logic [32-ADDR_W:31]   cmd_dst,
  input  logic [32-ADDR_W:31]   cmd_count,
  input  logic [0:DATA_W-1]     cmd_fill,
  output logic [32-ADDR_W:31]   address,
  output logic                  write_en,
  output logic [0:DATA_W-1]     data_out,
  input  logic [0:DATA_W-1]     data_in,
  output logic                  busy,
`ifdef MOVER_CHECKSUM_EN
  output logic [0:DATA_W-1]     checksum,
`endif
  output logic                  done
);

  mover_state_e r_state, w_state_d;

  logic [32-ADDR_W:31] r_src, r_dst, r_remaining;
  logic [32-ADDR_W:31] w_src_inc, w_dst_inc;
  logic [0:DATA_W-1]   r_hold, r_fill;
  logic                r_copy;
  logic                w_accept;

  assign w_src_inc = (r_src + ADDR_W'(1)) & ADDR_W'(SIGMA_ADDR_MASK);
  assign w_dst_inc = (r_dst + ADDR_W'(1)) & ADDR_W'(SIGMA_ADDR_MASK);

  // State register
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_d;
    end
  end

  // Next-state and bus/handshake decode; outputs depend on registers only
  always_comb begin
    w_state_d = r_state;
    w_accept  = 1'b0;
    cmd_ready = 1'b0;
    busy      = 1'b1;
    done      = 1'b0;
    address   = '0;
    write_en  = 1'b0;
    data_out  = '0;
    unique case (r_state)
      StIdle: begin
        cmd_ready = 1'b1;
        busy      = 1'b0;
        if (cmd_valid) begin
          w_accept = 1'b1;
          if (cmd_count == '0) begin
            w_state_d = StDone;
          end else if (cmd_copy) begin
            w_state_d = StRead;
          end else begin
            w_state_d = StWrite;
          end
        end
      end
      StRead: begin
        address   = r_src;
        w_state_d = StWrite;
      end
      StWrite: begin
        address  = r_dst;
        write_en = 1'b1;
        data_out = r_copy ? r_hold : r_fill;
        if (r_remaining == ADDR_W'(1)) begin
          w_state_d = StDone;
        end else if (r_copy) begin
          w_state_d = StRead;
        end else begin
          w_state_d = StWrite;
        end
      end
      StDone: begin
        done      = 1'b1;
        w_state_d = StIdle;
      end
      default: w_state_d = StIdle;
    endcase
  end

  // Command latch, pointer advance and read-data capture
  always_ff @(posedge clock) begin
    if (reset) begin
      r_src       <= '0;
      r_dst       <= '0;
      r_remaining <= '0;
      r_hold      <= '0;
      r_fill      <= '0;
      r_copy      <= 1'b0;
    end else if (w_accept) begin
      r_src       <= cmd_src;
      r_dst       <= cmd_dst;
      r_remaining <= cmd_count;
      r_fill      <= cmd_fill;
      r_copy      <= cmd_copy;
    end else begin
      if (r_state == StRead) begin
        r_hold <= data_in;
        r_src  <= w_src_inc;
      end
      if (r_state == StWrite) begin
        r_dst       <= w_dst_inc;
        r_remaining <= r_remaining - ADDR_W'(1);
      end
    end
  end

`ifdef MOVER_CHECKSUM_EN
  logic [0:DATA_W-1] r_checksum;

  // Running sum of written words; cleared per command, held after DONE
  always_ff @(posedge clock) begin
    if (reset) begin
      r_checksum <= '0;
    end else if (w_accept) begin
      r_checksum <= '0;
    end else if (r_state == StWrite) begin
      r_checksum <= r_checksum + data_out;
    end
  end

  assign checksum = r_checksum;
`endif

endmodule

// File: tb/tb_sigma_block_mover.sv
// Self-checking bench for sigma_block_mover: directed fill/copy/zero/wrap/reset
// cases followed by random commands, all checked against a word-array model.
module tb_sigma_block_mover;

  logic          clock = 1'b0;
  logic          reset;
  logic          cmd_valid, cmd_copy;
  logic [15:31]  cmd_src, cmd_dst, cmd_count;
  logic [0:31]   cmd_fill;
  logic          cmd_ready, write_en, busy, done;
  logic [15:31]  address;
  logic [0:31]   data_out, data_in;
`ifdef MOVER_CHECKSUM_EN
  logic [0:31]   checksum;
  logic [31:0]   exp_sum;
`endif

  logic [0:31]   mem     [0:131071];
  logic [0:31]   ref_mem [0:131071];
  logic          bd_we;
  logic [15:31]  bd_addr;
  logic [0:31]   bd_data;
  int            wr_cnt = 0;
  logic [15:31]  wr_log[$];
  int            n_cmp = 0;
  int            n_err = 0;

  sigma_block_mover u_dut (
    .clock     (clock),
    .reset     (reset),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_copy  (cmd_copy),
    .cmd_src   (cmd_src),
    .cmd_dst   (cmd_dst),
    .cmd_count (cmd_count),
    .cmd_fill  (cmd_fill),
    .address   (address),
    .write_en  (write_en),
    .data_out  (data_out),
    .data_in   (data_in),
    .busy      (busy),
`ifdef MOVER_CHECKSUM_EN
    .checksum  (checksum),
`endif
    .done      (done)
  );

  always #5 clock = ~clock;

  // Memory: combinational read, write on rising edge; backdoor only when DUT idle
  assign data_in = mem[address];
  always @(posedge clock) begin
    if (write_en === 1'b1) begin
      mem[address] <= data_out;
      wr_cnt       <= wr_cnt + 1;
      wr_log.push_back(address);
    end else if (bd_we) begin
      mem[bd_addr] <= bd_data;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic preload(input int a, input logic [31:0] v);
    bd_we   = 1'b1;
    bd_addr = 17'(a);
    bd_data = v;
    ref_mem[a & 'h1FFFF] = v;
    step();
    bd_we   = 1'b0;
  endtask

  task automatic cmp_region(input string tag, input int base, input int len);
    int bad;
    int a;
    bad = 0;
    for (int i = 0; i < len; i++) begin
      a = (base + i) & 'h1FFFF;
      if (mem[a] !== ref_mem[a]) bad++;
    end
    check(tag, 32'(bad), 32'd0);
  endtask

  // Reference: ascending word-by-word transfer, addresses wrap at 2^17
  task automatic model_apply(input bit copy, input int src, input int dst, input int n,
                             input logic [31:0] fill);
    logic [31:0] v;
`ifdef MOVER_CHECKSUM_EN
    exp_sum = 32'd0;
`endif
    for (int i = 0; i < n; i++) begin
      v = copy ? ref_mem[(src + i) & 'h1FFFF] : fill;
      ref_mem[(dst + i) & 'h1FFFF] = v;
`ifdef MOVER_CHECKSUM_EN
      exp_sum = exp_sum + v;
`endif
    end
  endtask

  // Issue one command in the current (idle) cycle and follow it to completion
  task automatic run_cmd(input string tag, input bit copy, input int src, input int dst,
                         input int n, input logic [31:0] fill);
    int lat_exp, cyc, busy_cyc, we_bad, w0;
    logic exp_we;
    lat_exp   = (n == 0) ? 1 : (copy ? 2 * n + 1 : n + 1);
    cmd_copy  = copy;
    cmd_src   = 17'(src);
    cmd_dst   = 17'(dst);
    cmd_count = 17'(n);
    cmd_fill  = fill;
    cmd_valid = 1'b1;
    check({tag, "_ready"}, 32'(cmd_ready), 32'd1);
    w0 = wr_cnt;
    model_apply(copy, src, dst, n, fill);
    step();
    cyc = 1; busy_cyc = 0; we_bad = 0;
    while (done !== 1'b1 && cyc < lat_exp + 8) begin
      if (busy === 1'b1) busy_cyc++;
      exp_we = (n == 0) ? 1'b0 : (copy ? (cyc % 2 == 0) : 1'b1);
      if (write_en !== exp_we) we_bad++;
      // Commands presented while busy must be ignored
      cmd_valid = 1'($urandom_range(0, 1));
      cmd_copy  = 1'($urandom_range(0, 1));
      cmd_src   = 17'($urandom);
      cmd_dst   = 17'($urandom);
      cmd_count = 17'($urandom_range(0, 5));
      cmd_fill  = $urandom;
      step();
      cyc++;
    end
    cmd_valid = 1'b0;
    check({tag, "_latency"}, 32'(cyc), 32'(lat_exp));
    if (busy === 1'b1) busy_cyc++;
    check({tag, "_busy_cycles"}, 32'(busy_cyc), 32'(lat_exp));
    check({tag, "_we_pattern"}, 32'(we_bad), 32'd0);
    check({tag, "_we_at_done"}, 32'(write_en), 32'd0);
`ifdef MOVER_CHECKSUM_EN
    check({tag, "_checksum"}, checksum, exp_sum);
`endif
    step();
    check({tag, "_idle"}, {30'd0, cmd_ready, busy}, 32'd2);
    check({tag, "_writes"}, 32'(wr_cnt - w0), 32'(n));
    cmp_region({tag, "_mem"}, dst, n + 1);
  endtask

  initial begin
    int w0;
    bit rc;
    int rs, rd, rn;
    reset = 1'b1; cmd_valid = 1'b0; cmd_copy = 1'b0;
    cmd_src = '0; cmd_dst = '0; cmd_count = '0; cmd_fill = '0;
    bd_we = 1'b0; bd_addr = '0; bd_data = '0;
    for (int i = 0; i < 131072; i++) ref_mem[i] = mem[i];
    step();
    step();
    check("rst_ready", 32'(cmd_ready), 32'd1);
    check("rst_busy_done_we", {29'd0, busy, done, write_en}, 32'd0);
    check("rst_address", 32'(address), 32'd0);
    check("rst_data_out", data_out, 32'd0);
`ifdef MOVER_CHECKSUM_EN
    check("rst_checksum", checksum, 32'd0);
`endif
    reset = 1'b0;
    step();

    for (int i = 0; i < 512; i++) preload(i, $urandom);

    // Fill of four words; 0x14 must survive
    run_cmd("fill4", 1'b0, 0, 'h10, 4, 32'hDEADBEEF);
    check("fill4_word13", mem['h13], 32'hDEADBEEF);

    // Copy of three words
    preload(0, 32'd1); preload(1, 32'd2); preload(2, 32'd3);
    run_cmd("copy3", 1'b1, 0, 'h40, 3, 32'h0);
    check("copy3_word42", mem['h42], 32'd3);

    // Zero-length command, then back-to-back commands
    run_cmd("zero", 1'b1, 'h20, 'h30, 0, 32'h0);
    run_cmd("b2b_fill1", 1'b0, 0, 'h50, 1, 32'h12345678);
    run_cmd("b2b_copy1", 1'b1, 'h50, 'h51, 1, 32'h0);

    // Address wrap
    w0 = wr_log.size();
    run_cmd("wrap", 1'b0, 0, 'h1FFFE, 3, 32'h5);
    check("wrap_addr0", 32'(wr_log[w0]), 32'h1FFFE);
    check("wrap_addr1", 32'(wr_log[w0 + 1]), 32'h1FFFF);
    check("wrap_addr2", 32'(wr_log[w0 + 2]), 32'h0);

    // Wrapping word sum
    preload('h80, 32'hFFFFFFFF); preload('h81, 32'h2);
    run_cmd("sum", 1'b1, 'h80, 'h90, 2, 32'h0);
`ifdef MOVER_CHECKSUM_EN
    check("sum_value", checksum, 32'h1);
`endif

    // Reset during the third WRITE of an 8-word copy
    cmd_copy = 1'b1; cmd_src = 17'h100; cmd_dst = 17'h180; cmd_count = 17'd8;
    cmd_valid = 1'b1;
    w0 = wr_cnt;
    step();
    cmd_valid = 1'b0;
    repeat (5) step();
    check("rstmid_we_w3", 32'(write_en), 32'd1);
    reset = 1'b1;
    step();
    check("rstmid_we", 32'(write_en), 32'd0);
    check("rstmid_ready", 32'(cmd_ready), 32'd1);
    reset = 1'b0;
    check("rstmid_writes", 32'(wr_cnt - w0), 32'd3);
    model_apply(1'b1, 'h100, 'h180, 3, 32'h0);
    cmp_region("rstmid_mem", 'h180, 9);
`ifdef MOVER_CHECKSUM_EN
    check("rstmid_checksum", checksum, 32'd0);
`endif
    step();

    // Random commands, including overlapping and wrapping ranges
    for (int k = 0; k < 40; k++) begin
      rc = 1'($urandom_range(0, 1));
      rs = $urandom_range(0, 511);
      rd = (k % 8 == 7) ? ('h1FFF8 + $urandom_range(0, 7)) : $urandom_range(0, 511);
      rn = $urandom_range(0, 20);
      run_cmd($sformatf("rand%0d", k), rc, rs, rd, rn, $urandom);
    end

    cmp_region("final_low", 0, 1024);
    cmp_region("final_top", 'h1FFE0, 32);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
